mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates one shared single-port memory bus between the instruction-fetch stage and the MEM stage of the MIPS pipeline. It sequences one bus transaction at a time with a req/ack handshake, returns read data to the owning requester, and drives per-requester stall signals that feed the pipeline `delay` inputs. Data accesses have priority; fetch is protected against starvation. Fetches are cancelled on interrupt/exception flush.

## Interface
- `STARVE_LIMIT`, default 4: consecutive MEM grants allowed while a fetch waits before fetch is forced; legal range 1..15.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_valid`.
- `if_addr`  in  32  fetch address.
- `mem_req`  in  1  data request; held high until `mem_valid`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_be`  in  4  store byte enables.
- `flush`  in  1  interrupt/exception; cancels fetch.
- `bus_req`  out  1  bus transaction request, registered.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  1/32/32/4  registered bus command.
- `bus_ack`  in  1  memory completes the current transaction; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read data.
- `if_valid` / `mem_valid`  out  1  one-cycle completion pulse.
- `if_rdata` / `mem_rdata`  out  32  registered read data; `mem_rdata` is 0 after stores.
- `if_stall` / `mem_stall`  out  1  combinational: `x_req & ~x_valid`.
- `owner`  out  2  00 = idle, 01 = IF, 10 = MEM, 11 = drain.

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_MEM, DRAIN. The `owner` output encodes the state.
- IDLE decision:
  - Force IF when `if_req & ~flush & starve_cnt == STARVE_LIMIT`.
  - Otherwise, if `mem_req`, go to GRANT_MEM.
  - Otherwise, if `if_req & ~flush`, go to GRANT_IF.
  - Otherwise, stay in IDLE.
- On a grant, register the command and set `bus_req` = 1.
  - IF command: `bus_we` = 0, `bus_be` = 1111, `bus_addr` = `if_addr`, `bus_wdata` = 0.
  - MEM command: `mem_*` values.
- The bus command is frozen while `bus_req` = 1.
- GRANT_x with `bus_ack` = 1: clear `bus_req`, capture `bus_rdata` into `x_rdata`, pulse `x_valid`, return to IDLE.
- GRANT_IF with `flush` = 1 and `bus_ack` = 0: go to DRAIN. In DRAIN, `bus_req` stays high; on `bus_ack`, discard data, raise no `if_valid`, return to IDLE.
- GRANT_IF with `flush` and `bus_ack` in the same cycle: the data is discarded and no `if_valid` pulse is raised.
- `flush` has no effect in GRANT_MEM.
- `starve_cnt` (4 bits):
  - +1, saturating at STARVE_LIMIT, on each MEM grant issued while `if_req` = 1.
  - Cleared on an IF grant, or in IDLE when `if_req` = 0.
- `bus_ack` is ignored in IDLE.
- `if_valid` and `mem_valid` are never high in the same cycle.
- Requesters may change address or data after their `x_valid` pulse only.

## Timing
- Reset (async): state = IDLE, `starve_cnt` = 0, all registered outputs = 0, `owner` = 00.
  - `bus_req` drops immediately on reset assertion, including mid-transaction.
  - No `x_valid` pulse is raised for a transaction aborted by reset.
- Request sampled high at edge N (IDLE): `bus_req` is high after edge N.
- `bus_ack` sampled at edge N+k (k ≥ 1): `x_valid` and `x_rdata` are valid for the cycle after edge N+k, and `bus_req` is low in that same cycle.
- Minimum latency from request to valid is 2 edges.
- One mandatory IDLE cycle separates transactions: maximum throughput is one transaction per 3 cycles with zero-wait memory.
- `x_stall` is combinational and deasserts in the `x_valid` cycle, so the stage advances at the next edge.

## Test plan
- Reset, then `if_req` = 1 with `if_addr` = 0x0000_0040 and memory acking in 1 cycle -> `bus_req` rises at edge 1; `if_valid` = 1 with `if_rdata` = `bus_rdata` after edge 2; `if_stall` = 0 in that cycle.
- `if_req` and `mem_req` both held high, `STARVE_LIMIT` = 4, MEM re-requesting continuously -> grant order MEM×4, IF, MEM×4, IF; `starve_cnt` is 0 after each IF grant.
- Store with `mem_addr` = 0x100, `mem_wdata` = 0xDEADBEEF, `mem_be` = 0011 -> `bus_we` = 1 and `bus_be` = 0011 are held until ack; `mem_valid` pulses with `mem_rdata` = 0.
- Fetch in flight with 3 wait cycles, `flush` raised on wait cycle 1 -> `owner` = 11, `bus_req` is held until ack, no `if_valid` pulse, then IDLE. A `flush` coincident with `bus_ack` also produces no `if_valid`.
- `flush` high in IDLE with only `if_req` pending -> no grant while `flush` = 1; the grant occurs on the first edge after `flush` falls.
- Assert `reset` asynchronously mid-GRANT_MEM -> `bus_req` falls before the next clock edge; a later stray `bus_ack` produces no valid pulse; the next request proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// Data accesses win by default; a fetch is forced after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        if_valid,
    output logic        mem_valid,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        mem_stall,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT_IF  = 2'b01,
        GRANT_MEM = 2'b10,
        DRAIN     = 2'b11
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       fetch_ok;
    logic       force_if;
    logic       completing;

    assign fetch_ok   = if_req & ~flush;
    assign force_if   = fetch_ok & (starve_cnt == LIMIT);
    // During a valid pulse the requester still holds its old request, so no grant is issued.
    assign completing = if_valid | mem_valid;

    assign owner     = state;
    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = mem_req & ~mem_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!if_req)
                        starve_cnt <= '0;
                    if (!completing) begin
                        if (force_if || (fetch_ok && !mem_req)) begin
                            state      <= GRANT_IF;
                            bus_req    <= 1'b1;
                            bus_we     <= 1'b0;
                            bus_addr   <= if_addr;
                            bus_wdata  <= '0;
                            bus_be     <= 4'b1111;
                            starve_cnt <= '0;
                        end else if (mem_req) begin
                            state     <= GRANT_MEM;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_we;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                            bus_be    <= mem_be;
                            if (if_req && starve_cnt < LIMIT)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                GRANT_IF: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                        if (!flush) begin
                            if_valid <= 1'b1;
                            if_rdata <= bus_rdata;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                GRANT_MEM: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        state     <= IDLE;
                        mem_valid <= 1'b1;
                        mem_rdata <= bus_we ? 32'd0 : bus_rdata;
                    end
                end
                DRAIN: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
